// File: rtl/screen_mode_controller.sv
// screen_mode_controller: debounces the controller buttons, routes press pulses to the
// active screen and commits mode switches only on VGA frame boundaries.
`default_nettype none

module screen_mode_controller #(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] buttons,
  input  logic       screen_end,
  input  logic [1:0] home_sel,
  output logic       home_fsm_en,
  output logic [1:0] mode,
  output logic       mode_changed,
  output logic [7:0] btn_press
);

  localparam int             CNT_W   = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  localparam int BIT_A = 4;
  localparam int BIT_B = 5;

  localparam logic [7:0] HOME_FWD_MASK = 8'b1110_1111;
  localparam logic [7:0] APP_FWD_MASK  = 8'b1101_1111;

  typedef enum logic [1:0] {
    S_HOME   = 2'd0,
    S_SWITCH = 2'd1,
    S_APP    = 2'd2
  } state_t;

  logic [7:0]       sync1;
  logic [7:0]       sync2;
  logic [7:0]       deb;
  logic [7:0]       deb_d;
  logic [CNT_W-1:0] cnt [8];
  logic             screen_end_d;

  state_t           state;
  logic [1:0]       target;

  logic [7:0]       press;
  logic             frame_edge;

  assign press      = deb & ~deb_d;
  assign frame_edge = screen_end & ~screen_end_d;

  // Debounced level only follows the synchronized input after it has stayed
  // different for DEBOUNCE_CYCLES consecutive cycles.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1        <= '0;
      sync2        <= '0;
      deb          <= '0;
      deb_d        <= '0;
      screen_end_d <= 1'b0;
      for (int i = 0; i < 8; i++) cnt[i] <= '0;
    end else begin
      sync1        <= buttons;
      sync2        <= sync1;
      deb_d        <= deb;
      screen_end_d <= screen_end;
      for (int i = 0; i < 8; i++) begin
        if (sync2[i] == deb[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_MAX) begin
          deb[i] <= sync2[i];
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= S_HOME;
      target       <= 2'b00;
      mode         <= 2'b00;
      mode_changed <= 1'b0;
      home_fsm_en  <= 1'b1;
      btn_press    <= '0;
    end else begin
      mode_changed <= 1'b0;
      case (state)
        S_HOME: begin
          btn_press <= press & HOME_FWD_MASK;
          // A frame edge coinciding with the A press is deliberately ignored.
          if (press[BIT_A] && home_sel != 2'b11) begin
            target      <= home_sel + 2'b01;
            state       <= S_SWITCH;
            home_fsm_en <= 1'b0;
          end
        end
        S_SWITCH: begin
          btn_press <= '0;
          if (frame_edge) begin
            mode         <= target;
            mode_changed <= 1'b1;
            if (target == 2'b00) begin
              state       <= S_HOME;
              home_fsm_en <= 1'b1;
            end else begin
              state <= S_APP;
            end
          end
        end
        S_APP: begin
          btn_press <= press & APP_FWD_MASK;
          if (press[BIT_B]) begin
            target <= 2'b00;
            state  <= S_SWITCH;
          end
        end
        default: begin
          state       <= S_HOME;
          home_fsm_en <= 1'b1;
          btn_press   <= '0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire
